// File: rtl/apb_fsm_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_bridge_pkg
//  Description : Shared types and constants for the AHB-to-APB bridge FSM
//                controller: state encoding, AHB response codes, the APB
//                slave address map and a small next-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_READ     = 4'd1,
        ST_RENABLE  = 4'd2,
        ST_WWAIT    = 4'd3,
        ST_WRITE    = 4'd4,
        ST_WRITEP   = 4'd5,
        ST_WENABLE  = 4'd6,
        ST_WENABLEP = 4'd7,
        ST_ERR      = 4'd8
    } apb_state_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // APB slave windows; each slave owns a 64 MB region.
    localparam logic [31:0] c_slv0_base   = 32'h8000_0000;
    localparam logic [31:0] c_slv1_base   = 32'h8400_0000;
    localparam logic [31:0] c_slv2_base   = 32'h8800_0000;
    localparam logic [31:0] c_region_mask = 32'hFC00_0000;

    // Where the FSM goes when it is free to accept a new AHB transfer.
    function automatic apb_state_t req_next_state(input logic valid, input logic hwrite);
        apb_state_t nxt;
        if (!valid) begin
            nxt = ST_IDLE;
        end else if (hwrite) begin
            nxt = ST_WWAIT;
        end else begin
            nxt = ST_READ;
        end
        return nxt;
    endfunction

endpackage : apb_bridge_pkg
`default_nettype wire

// File: rtl/apb_fsm_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fsm_controller_if
//  Description : Bundles the pipelined AHB transfer inputs and the APB /
//                AHB-response outputs of apb_fsm_controller.
//                slave  : view used by the controller
//                master : view used by the surrounding logic / bench
//                Build macro APB_PSLVERR_EN adds pslverr (to controller)
//                and hresp (from controller).
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_fsm_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
);
    logic              valid;
    logic              hwrite;
    logic              hwrite_reg;
    logic [ADDR_W-1:0] haddr;
    logic [ADDR_W-1:0] haddr1;
    logic [ADDR_W-1:0] haddr2;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hwdata1;
    logic [NSLV-1:0]   temp_selx;
    logic [NSLV-1:0]   pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              hreadyout;
`ifdef APB_PSLVERR_EN
    logic              pslverr;
    logic [1:0]        hresp;

    modport slave (
        input  valid, hwrite, hwrite_reg, haddr, haddr1, haddr2,
               hwdata, hwdata1, temp_selx, pslverr,
        output pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp
    );
    modport master (
        output valid, hwrite, hwrite_reg, haddr, haddr1, haddr2,
               hwdata, hwdata1, temp_selx, pslverr,
        input  pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp
    );
`else
    modport slave (
        input  valid, hwrite, hwrite_reg, haddr, haddr1, haddr2,
               hwdata, hwdata1, temp_selx,
        output pselx, penable, pwrite, paddr, pwdata, hreadyout
    );
    modport master (
        output valid, hwrite, hwrite_reg, haddr, haddr1, haddr2,
               hwdata, hwdata1, temp_selx,
        input  pselx, penable, pwrite, paddr, pwdata, hreadyout
    );
`endif
endinterface : apb_fsm_controller_if
`default_nettype wire

// File: rtl/apb_fsm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : apb_fsm_controller
//  Description : APB sequencer of the AHB-to-APB bridge. Turns decoded,
//                pipelined AHB transfers into APB SETUP/ACCESS phases for
//                single and back-to-back transfers, stalling the AHB master
//                through hreadyout. All outputs are registered and take the
//                value belonging to the state being entered.
//  Ports       : hclk    - bridge clock
//                hresetn - asynchronous active-low reset
//                bus     - apb_fsm_controller_if.slave (AHB transfer in,
//                          pselx/penable/pwrite/paddr/pwdata/hreadyout out)
//  Options     : APB_PSLVERR_EN - pslverr input, hresp output and a
//                two-cycle AHB ERROR response state
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_fsm_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    apb_fsm_controller_if.slave  bus
);

    apb_state_t        r_state,     w_state_nxt;
    logic [NSLV-1:0]   r_pselx,     w_pselx;
    logic              r_penable,   w_penable;
    logic              r_pwrite,    w_pwrite;
    logic [ADDR_W-1:0] r_paddr,     w_paddr;
    logic [DATA_W-1:0] r_pwdata,    w_pwdata;
    logic              r_hreadyout, w_hreadyout;
`ifdef APB_PSLVERR_EN
    logic [1:0]        r_hresp,     w_hresp;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pselx     = '0;
        w_penable   = 1'b0;
        w_pwrite    = 1'b0;
        w_paddr     = '0;
        w_pwdata    = '0;
        w_hreadyout = 1'b1;
`ifdef APB_PSLVERR_EN
        w_hresp     = HRESP_OKAY;
`endif

        // Next state
        case (r_state)
            ST_IDLE:     w_state_nxt = req_next_state(bus.valid, bus.hwrite);
            ST_READ:     w_state_nxt = ST_RENABLE;
            ST_RENABLE,
            ST_WENABLE:  w_state_nxt = req_next_state(bus.valid, bus.hwrite);
            ST_WWAIT:    w_state_nxt = bus.valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:    w_state_nxt = bus.valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   w_state_nxt = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!bus.hwrite_reg) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = bus.valid ? ST_WRITEP : ST_WRITE;
                end
            end
`ifdef APB_PSLVERR_EN
            // Second cycle of the AHB error response goes out on the way
            // back to idle: ERROR with hreadyout high.
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
                w_hresp     = HRESP_ERROR;
            end
`endif
            default:     w_state_nxt = ST_IDLE;
        endcase

`ifdef APB_PSLVERR_EN
        // A slave error seen during any ACCESS phase overrides the normal exit.
        if (bus.pslverr && (r_state == ST_RENABLE || r_state == ST_WENABLE ||
                            r_state == ST_WENABLEP)) begin
            w_state_nxt = ST_ERR;
        end
`endif

        // Output values belonging to the state about to be entered
        case (w_state_nxt)
            ST_READ: begin
                w_pselx     = bus.temp_selx;
                w_paddr     = bus.haddr;
                w_hreadyout = 1'b0;
            end
            ST_RENABLE: begin
                w_pselx     = r_pselx;
                w_paddr     = r_paddr;
                w_penable   = 1'b1;
            end
            ST_WRITE: begin
                w_pselx     = bus.temp_selx;
                w_paddr     = bus.haddr1;
                w_pwdata    = bus.hwdata;
                w_pwrite    = 1'b1;
                w_hreadyout = 1'b0;
            end
            // Pipelined write: the address/data of the older transfer sit
            // one stage further down the delay line.
            ST_WRITEP: begin
                w_pselx     = bus.temp_selx;
                w_paddr     = bus.haddr2;
                w_pwdata    = bus.hwdata1;
                w_pwrite    = 1'b1;
                w_hreadyout = 1'b0;
            end
            ST_WENABLE,
            ST_WENABLEP: begin
                w_pselx     = r_pselx;
                w_paddr     = r_paddr;
                w_pwdata    = r_pwdata;
                w_pwrite    = r_pwrite;
                w_penable   = 1'b1;
            end
`ifdef APB_PSLVERR_EN
            ST_ERR: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
            end
`endif
            default: ;   // ST_IDLE / ST_WWAIT: bus idle, master released
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= ST_IDLE;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_hreadyout <= 1'b1;
`ifdef APB_PSLVERR_EN
            r_hresp     <= HRESP_OKAY;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pselx     <= w_pselx;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_hreadyout <= w_hreadyout;
`ifdef APB_PSLVERR_EN
            r_hresp     <= w_hresp;
`endif
        end
    end

    assign bus.pselx     = r_pselx;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.hreadyout = r_hreadyout;
`ifdef APB_PSLVERR_EN
    assign bus.hresp     = r_hresp;
`endif

endmodule : apb_fsm_controller
`default_nettype wire

// File: tb/tb_apb_fsm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_fsm_controller
//  Description : Self-checking bench for apb_fsm_controller. Directed AHB
//                vectors drive every controller input each cycle; expected
//                APB phases are queued as stimulus is issued and a monitor
//                pops and compares whenever the APB bus is active or the
//                master is stalled. Covers the APB_PSLVERR_EN error
//                response when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_fsm_controller;

    logic hclk;
    logic hresetn;

    apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        en;
        logic        rdy;
    } apb_obs_t;

    apb_obs_t sb_q[$];
    apb_obs_t mon_obs;
    int       n_vec = 0;
    int       n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic en, input logic rdy);
        apb_obs_t e;
        e = '{sel: s, addr: a, wr: w, wdata: d, en: en, rdy: rdy};
        sb_q.push_back(e);
    endtask

    // One AHB-side cycle: drive all inputs, then advance past the next edge.
    task automatic drv(input logic v, input logic hw, input logic hwr,
                       input logic [31:0] a, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] d, input logic [31:0] d1, input logic [2:0] sel);
        bus.valid      = v;
        bus.hwrite     = hw;
        bus.hwrite_reg = hwr;
        bus.haddr      = a;
        bus.haddr1     = a1;
        bus.haddr2     = a2;
        bus.hwdata     = d;
        bus.hwdata1    = d1;
        bus.temp_selx  = sel;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    endtask

    // Monitor: any cycle with a select, an enable or a stalled master is an
    // APB phase and must match the next queued expectation.
    always @(negedge hclk) begin
        if (hresetn && (bus.pselx != 3'b000 || bus.penable || !bus.hreadyout)) begin
            mon_obs = '{sel: bus.pselx, addr: bus.paddr, wr: bus.pwrite,
                        wdata: bus.pwdata, en: bus.penable, rdy: bus.hreadyout};
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL apb_unexpected: got %0h, expected no activity", mon_obs);
            end else begin
                chk("apb_phase", 128'(mon_obs), 128'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] A_RD = 32'h8000_0010;
    localparam logic [31:0] A_WR = 32'h8400_0004;
    localparam logic [31:0] D_WR = 32'hDEAD_BEEF;
    localparam logic [31:0] A0   = 32'h8800_0000;
    localparam logic [31:0] A1   = 32'h8800_0004;
    localparam logic [31:0] D0   = 32'h1111_0000;
    localparam logic [31:0] D1   = 32'h2222_0004;
    localparam logic [31:0] AW   = 32'h8000_0020;
    localparam logic [31:0] DW   = 32'h5A5A_0020;
    localparam logic [31:0] AR   = 32'h8000_0024;
    localparam logic [31:0] AC   = 32'h8400_0100;
    localparam logic [31:0] AX   = 32'h9000_0000;

    initial begin
        hresetn = 1'b0;
`ifdef APB_PSLVERR_EN
        bus.pslverr = 1'b0;
`endif
        bus.valid = 1'b0; bus.hwrite = 1'b0; bus.hwrite_reg = 1'b0;
        bus.haddr = '0; bus.haddr1 = '0; bus.haddr2 = '0;
        bus.hwdata = '0; bus.hwdata1 = '0; bus.temp_selx = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_pselx",   128'(bus.pselx),     128'(3'b000));
        chk("rst_penable", 128'(bus.penable),   128'(1'b0));
        chk("rst_pwrite",  128'(bus.pwrite),    128'(1'b0));
        chk("rst_paddr",   128'(bus.paddr),     128'(32'h0));
        chk("rst_pwdata",  128'(bus.pwdata),    128'(32'h0));
        chk("rst_hready",  128'(bus.hreadyout), 128'(1'b1));
`ifdef APB_PSLVERR_EN
        chk("rst_hresp",   128'(bus.hresp),     128'(2'b00));
`endif
        hresetn = 1'b1;

        // Single read
        push(3'b001, A_RD, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, A_RD, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        push(3'b001, A_RD, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        idle();
        chk("read_then_idle", 128'({bus.pselx, bus.penable, bus.hreadyout}), 128'({3'b000, 1'b0, 1'b1}));

        // Single write: wait cycle, then SETUP/ACCESS
        drv(1'b1, 1'b1, 1'b0, A_WR, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010);
        chk("wwait_no_sel", 128'({bus.pselx, bus.hreadyout}), 128'({3'b000, 1'b1}));
        push(3'b010, A_WR, 1'b1, D_WR, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, 32'h0, A_WR, 32'h0, D_WR, 32'h0, 3'b010);
        push(3'b010, A_WR, 1'b1, D_WR, 1'b1, 1'b1);
        idle();
        idle();

        // Back-to-back writes: WWAIT->WRITEP->WENABLEP->WRITE->WENABLE
        drv(1'b1, 1'b1, 1'b0, A0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b100);
        push(3'b100, A0, 1'b1, D0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b1, A1, A0, A0, D0, D0, 3'b100);
        push(3'b100, A0, 1'b1, D0, 1'b1, 1'b1);
        drv(1'b1, 1'b1, 1'b1, A1, A1, A0, D0, D0, 3'b100);
        push(3'b100, A1, 1'b1, D1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, 32'h0, A1, A1, D1, D0, 3'b100);
        push(3'b100, A1, 1'b1, D1, 1'b1, 1'b1);
        idle();
        idle();

        // Write followed by read: WENABLEP->READ
        drv(1'b1, 1'b1, 1'b0, AW, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        push(3'b001, AW, 1'b1, DW, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b1, AR, AW, AW, DW, DW, 3'b001);
        push(3'b001, AW, 1'b1, DW, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 1'b0, AR, AR, AW, DW, DW, 3'b001);
        push(3'b001, AR, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, AR, AR, AR, 32'h0, DW, 3'b001);
        push(3'b001, AR, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        idle();

        // Back-to-back reads: RENABLE->READ
        push(3'b001, A_RD, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, A_RD, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        push(3'b001, A_RD, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        push(3'b010, AC, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, AC, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010);
        push(3'b010, AC, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        idle();

        // Reset asserted in the middle of a write SETUP
        drv(1'b1, 1'b1, 1'b0, A_WR, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010);
        drv(1'b0, 1'b0, 1'b1, 32'h0, A_WR, 32'h0, D_WR, 32'h0, 3'b010);
        chk("midwr_pwrite", 128'(bus.pwrite), 128'(1'b1));
        #1 hresetn = 1'b0;
        #1;
        chk("midwr_rst_pselx",   128'(bus.pselx),     128'(3'b000));
        chk("midwr_rst_penable", 128'(bus.penable),   128'(1'b0));
        chk("midwr_rst_hready",  128'(bus.hreadyout), 128'(1'b1));
        @(posedge hclk);
        #1 hresetn = 1'b1;
        idle();
        chk("post_rst_idle", 128'({bus.pselx, bus.penable, bus.hreadyout}), 128'({3'b000, 1'b0, 1'b1}));

        // Transfer with no slave selected still sequences
        push(3'b000, AX, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, AX, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
        push(3'b000, AX, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        idle();

`ifdef APB_PSLVERR_EN
        // Slave error during read ACCESS: two-cycle AHB ERROR response
        push(3'b001, A_RD, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, A_RD, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        push(3'b001, A_RD, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        chk("err_pre_hresp", 128'(bus.hresp), 128'(2'b00));
        bus.pslverr = 1'b1;
        push(3'b000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        bus.pslverr = 1'b0;
        chk("err1_hresp",  128'(bus.hresp),     128'(2'b01));
        chk("err1_hready", 128'(bus.hreadyout), 128'(1'b0));
        idle();
        chk("err2_hresp",  128'(bus.hresp),     128'(2'b01));
        chk("err2_hready", 128'(bus.hreadyout), 128'(1'b1));
        idle();
        chk("err3_hresp",  128'(bus.hresp),     128'(2'b00));
        chk("err3_hready", 128'(bus.hreadyout), 128'(1'b1));
        idle();
`endif

        idle();
        chk("sb_drain", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_apb_fsm_controller
`default_nettype wire
